ps2_number_entry: RTL and testbench
===================================

# ps2_number_entry

Sequential, parametrised successor to the team's combinational PS/2 scan-code-to-digit decoder. Consumes a stream of PS/2 Set-2 scan-code bytes, tracks make/break/extended prefixes, and accumulates up to MAX_DIGITS decimal digits in a BCD entry buffer with backspace and clear. On Enter, it converts the buffer to binary over a fixed number of cycles and emits a one-cycle-valid result. Sits between the PS/2 byte receiver and the datapath and display logic (HEX/LEDR).

## Interface
Parameters:
- MAX_DIGITS, 3: digit capacity of the entry buffer, range 1..6.
- VALUE_W, 10: width of the binary result; must satisfy 2^VALUE_W > 10^MAX_DIGITS - 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock; clears all state.
- code  in  8  scan-code byte from the PS/2 receiver.
- code_valid  in  1  one-cycle strobe; `code` is valid while this is high.
- busy  out  1  high during conversion; bytes strobed while busy are dropped.
- bcd_digits  out  4*MAX_DIGITS  entry buffer, right-aligned BCD, digit 0 in [3:0], unused digits 0.
- digit_count  out  3  number of digits entered, 0..MAX_DIGITS.
- entry_full  out  1  high when digit_count == MAX_DIGITS.
- value_out  out  VALUE_W  last committed binary value; held until the next commit.
- value_valid  out  1  one-cycle pulse when value_out updates.
- LEDR  out  8  value_out[7:0], zero-extended if VALUE_W < 8.

## Operation
- Prefix FSM states are MAKE, BREAK, EXT and EXT_BREAK. Transitions occur only on accepted bytes (code_valid high and busy low).
  - MAKE: F0 goes to BREAK; E0 goes to EXT; any other byte is decoded as a make code and the state stays MAKE.
  - BREAK: the next byte is consumed without action and the state returns to MAKE.
  - EXT: F0 goes to EXT_BREAK; E0 stays in EXT; 5A is decoded as Enter; any other byte is ignored. Except for E0 and F0, the state returns to MAKE.
  - EXT_BREAK: the next byte is consumed and the state returns to MAKE.
- Make-code decode (MAKE state only):
  - Digits: 0 = 45/70, 1 = 16/69, 2 = 1E/72, 3 = 26/7A, 4 = 25/6B, 5 = 2E/73, 6 = 36/74, 7 = 3D/6C, 8 = 3E/75, 9 = 46/7D.
  - Control keys: 5A = Enter, 66 = Backspace, 76 = Escape. All other bytes are ignored.
  - Typematic repeats (the same make code with no break) count as new key presses.
- Digit handling:
  - If digit_count < MAX_DIGITS: bcd_digits becomes {bcd_digits[4*MAX_DIGITS-5:0], d} and digit_count increments.
  - If the buffer is full, the digit is ignored and the buffer is unchanged.
- Backspace: shift bcd_digits right by one digit (zero fill) and decrement digit_count. No effect when digit_count is 0.
- Escape: clear bcd_digits and digit_count. value_out is unchanged.
- Enter:
  - If digit_count is 0, Enter is ignored.
  - Otherwise the control FSM moves from IDLE to CONV, busy rises, and an accumulator acc is cleared.
  - CONV runs exactly MAX_DIGITS cycles, most significant digit first: acc = acc*10 + digit[i]. Leading zeros are harmless.
  - The state then moves to DONE for one cycle: value_out <= acc, value_valid = 1, the buffer and digit_count are cleared, busy falls, and the FSM returns to IDLE.
- Arithmetic: acc is VALUE_W bits wide. acc*10 is computed as (acc<<3)+(acc<<1), truncated to VALUE_W. Truncation cannot occur when the parameter constraint holds.
- Reset values: prefix FSM = MAKE, control FSM = IDLE, bcd_digits = 0, digit_count = 0, value_out = 0, value_valid = 0, busy = 0, LEDR = 0.
- Reset during CONV aborts the conversion: no value_valid pulse, value_out = 0.

## Timing
- Digit, Backspace and Escape take effect on the clock edge that samples code_valid. bcd_digits and digit_count are updated on the next cycle.
- Enter accepted at edge T:
  - busy is high from T+1 through T+MAX_DIGITS.
  - value_valid is high for the single cycle T+MAX_DIGITS+1, with value_out valid from that cycle onward.
  - busy is low in cycle T+MAX_DIGITS+1.
- Latency from Enter to value_valid is MAX_DIGITS+1 cycles, independent of digit_count.
- Bytes strobed while busy are lost and do not advance the prefix FSM. The upstream block is responsible for not sending during busy.
- A byte strobed in the value_valid cycle is accepted normally.
- Back-to-back code_valid on consecutive cycles must be supported: one byte per cycle.

## Test plan
- Reset, then bytes 16, F0, 16, 1E, F0, 1E, 26, F0, 26, 5A.
  - Required: bcd_digits = 0x123 before Enter.
  - Required: busy high for 3 cycles, then value_valid pulse with value_out = 123 (LEDR = 0x7B), and digit_count = 0 afterwards.
- Keypad path: 69, 70, E0 5A.
  - Required: value_out = 10 exactly MAX_DIGITS+1 cycles after the 5A.
  - Required: E0 F0 5A afterwards produces no pulse.
- Overflow and backspace (MAX_DIGITS = 3): 46, 46, 46, 16 gives entry_full = 1 and bcd = 0x999.
  - Then 66 gives bcd = 0x099, count = 2.
  - Then 45, 5A gives value_out = 990.
- Escape and empty Enter: 25, 76 clears the buffer. A following 5A produces no value_valid and value_out keeps its previous value.
- Busy drop: Enter on 0x7, then strobe 16 during busy.
  - Required: the byte is ignored, the buffer is empty after DONE, and the prefix FSM is in MAKE.
- Reset mid-CONV: assert reset on the second busy cycle.
  - Required: no pulse, all outputs 0 the cycle after reset, normal entry works afterwards.
  - Repeat with MAX_DIGITS = 6, VALUE_W = 20, entry 999999 -> value_out = 999999.

Source files
------------

// File: rtl/ps2_number_entry.sv
// PS/2 Set-2 scan-code number entry: prefix tracking, BCD entry buffer,
// and a digit-serial BCD-to-binary conversion triggered by Enter.
module ps2_number_entry #(
  parameter int MAX_DIGITS = 3,
  parameter int VALUE_W    = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              code,
  input  logic                    code_valid,
  output logic                    busy,
  output logic [4*MAX_DIGITS-1:0] bcd_digits,
  output logic [2:0]              digit_count,
  output logic                    entry_full,
  output logic [VALUE_W-1:0]      value_out,
  output logic                    value_valid,
  output logic [7:0]              LEDR
);

  localparam int         BW   = 4 * MAX_DIGITS;
  localparam logic [2:0] MAXC = 3'(MAX_DIGITS);

  typedef enum logic [1:0] {
    P_MAKE, P_BREAK, P_EXT, P_EXT_BREAK
  } pfx_t;

  typedef enum logic [1:0] {
    C_IDLE, C_CONV, C_DONE
  } ctl_t;

  pfx_t               r_pfx, w_pfx_n;
  ctl_t               r_ctl, w_ctl_n;
  logic [BW-1:0]      r_bcd, w_bcd_n;
  logic [2:0]         r_cnt, w_cnt_n;
  logic [2:0]         r_idx, w_idx_n;
  logic [VALUE_W-1:0] r_acc, w_acc_n;
  logic [VALUE_W-1:0] r_value, w_value_n;

  logic               w_dig_hit;
  logic [3:0]         w_dig;
  logic               w_accept;
  logic               w_make;
  logic               w_enter;
  logic [BW+3:0]      w_shl;
  logic [3:0]         w_cur;
  logic [VALUE_W-1:0] w_acc_next;

  always_comb begin
    w_dig_hit = 1'b1;
    w_dig     = 4'd0;
    case (code)
      8'h45, 8'h70: w_dig = 4'd0;
      8'h16, 8'h69: w_dig = 4'd1;
      8'h1E, 8'h72: w_dig = 4'd2;
      8'h26, 8'h7A: w_dig = 4'd3;
      8'h25, 8'h6B: w_dig = 4'd4;
      8'h2E, 8'h73: w_dig = 4'd5;
      8'h36, 8'h74: w_dig = 4'd6;
      8'h3D, 8'h6C: w_dig = 4'd7;
      8'h3E, 8'h75: w_dig = 4'd8;
      8'h46, 8'h7D: w_dig = 4'd9;
      default:      w_dig_hit = 1'b0;
    endcase
  end

  assign w_accept = code_valid && (r_ctl != C_CONV);
  assign w_make   = w_accept && (r_pfx == P_MAKE);
  assign w_enter  = w_accept && (code == 8'h5A) &&
                    ((r_pfx == P_MAKE) || (r_pfx == P_EXT));

  assign w_shl = {r_bcd, w_dig};
  assign w_cur = 4'(r_bcd >> {r_idx, 2'b00});
  // acc*10 as shift-add, truncated to the result width
  assign w_acc_next = (r_acc << 3) + (r_acc << 1) +
                      VALUE_W'(w_cur);

  always_comb begin
    w_pfx_n   = r_pfx;
    w_ctl_n   = r_ctl;
    w_bcd_n   = r_bcd;
    w_cnt_n   = r_cnt;
    w_idx_n   = r_idx;
    w_acc_n   = r_acc;
    w_value_n = r_value;

    if (w_accept) begin
      case (r_pfx)
        P_MAKE: begin
          if (code == 8'hF0)      w_pfx_n = P_BREAK;
          else if (code == 8'hE0) w_pfx_n = P_EXT;
          else                    w_pfx_n = P_MAKE;
        end
        P_EXT: begin
          if (code == 8'hF0)      w_pfx_n = P_EXT_BREAK;
          else if (code == 8'hE0) w_pfx_n = P_EXT;
          else                    w_pfx_n = P_MAKE;
        end
        default: w_pfx_n = P_MAKE;
      endcase
    end

    if (w_make && w_dig_hit) begin
      if (r_cnt < MAXC) begin
        w_bcd_n = w_shl[BW-1:0];
        w_cnt_n = r_cnt + 3'd1;
      end
    end else if (w_make && code == 8'h66) begin
      if (r_cnt != 3'd0) begin
        w_bcd_n = r_bcd >> 4;
        w_cnt_n = r_cnt - 3'd1;
      end
    end else if (w_make && code == 8'h76) begin
      w_bcd_n = '0;
      w_cnt_n = 3'd0;
    end

    case (r_ctl)
      C_CONV: begin
        w_acc_n = w_acc_next;
        w_idx_n = r_idx - 3'd1;
        if (r_idx == 3'd0) begin
          w_ctl_n   = C_DONE;
          w_value_n = w_acc_next;
          w_bcd_n   = '0;
          w_cnt_n   = 3'd0;
        end
      end
      default: begin
        w_ctl_n = C_IDLE;
        if (w_enter && r_cnt != 3'd0) begin
          w_ctl_n = C_CONV;
          w_acc_n = '0;
          w_idx_n = MAXC - 3'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pfx   <= P_MAKE;
      r_ctl   <= C_IDLE;
      r_bcd   <= '0;
      r_cnt   <= 3'd0;
      r_idx   <= 3'd0;
      r_acc   <= '0;
      r_value <= '0;
    end else begin
      r_pfx   <= w_pfx_n;
      r_ctl   <= w_ctl_n;
      r_bcd   <= w_bcd_n;
      r_cnt   <= w_cnt_n;
      r_idx   <= w_idx_n;
      r_acc   <= w_acc_n;
      r_value <= w_value_n;
    end
  end

  assign busy        = (r_ctl == C_CONV);
  assign value_valid = (r_ctl == C_DONE);
  assign bcd_digits  = r_bcd;
  assign digit_count = r_cnt;
  assign entry_full  = (r_cnt == MAXC);
  assign value_out   = r_value;

  generate
    if (VALUE_W >= 8) begin : g_led_wide
      assign LEDR = r_value[7:0];
    end else begin : g_led_narrow
      assign LEDR = {{(8-VALUE_W){1'b0}}, r_value};
    end
  endgenerate

endmodule

// File: tb/tb_ps2_number_entry.sv
// Bench for ps2_number_entry: directed table, hand sequences and random
// bytes against a digit-list reference model, on a 3-digit and a 6-digit DUT.
module tb_ps2_number_entry;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [7:0] code = 8'h00;
  logic       code_valid = 1'b0;

  logic        busy3, vv3, full3;
  logic [11:0] bcd3;
  logic [2:0]  cnt3;
  logic [9:0]  val3;
  logic [7:0]  led3;

  logic        busy6, vv6, full6;
  logic [23:0] bcd6;
  logic [2:0]  cnt6;
  logic [19:0] val6;
  logic [7:0]  led6;

  ps2_number_entry #(.MAX_DIGITS(3), .VALUE_W(10)) dut3 (
    .clk(clk), .reset(reset), .code(code), .code_valid(code_valid),
    .busy(busy3), .bcd_digits(bcd3), .digit_count(cnt3),
    .entry_full(full3), .value_out(val3), .value_valid(vv3),
    .LEDR(led3)
  );

  ps2_number_entry #(.MAX_DIGITS(6), .VALUE_W(20)) dut6 (
    .clk(clk), .reset(reset), .code(code), .code_valid(code_valid),
    .busy(busy6), .bcd_digits(bcd6), .digit_count(cnt6),
    .entry_full(full6), .value_out(val6), .value_valid(vv6),
    .LEDR(led6)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the entry is a list of digits (MSD first), prefixes
  // are two flags, and a conversion is a countdown plus a precomputed sum.
  int     kmain[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                        8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  int     kpad[10]  = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B,
                        8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
  int     mdig[2][6];
  int     mn[2];
  bit     mbrk[2], mext[2], mvv[2];
  int     mbusy[2];
  longint mval[2], mpend[2];

  function automatic int dig_of(logic [7:0] b);
    for (int i = 0; i < 10; i++)
      if (b == kmain[i][7:0] || b == kpad[i][7:0]) return i;
    return -1;
  endfunction

  function automatic void start_conv(int k, int md);
    longint s = 0;
    if (mn[k] == 0) return;
    for (int i = 0; i < mn[k]; i++) s = s * 10 + mdig[k][i];
    mpend[k] = s;
    mbusy[k] = md;
  endfunction

  function automatic void model_edge(bit r, bit v, logic [7:0] b);
    for (int k = 0; k < 2; k++) begin
      int md = (k == 0) ? 3 : 6;
      int d = dig_of(b);
      if (r) begin
        mn[k] = 0; mbrk[k] = 0; mext[k] = 0;
        mvv[k] = 0; mbusy[k] = 0; mval[k] = 0;
      end else begin
        mvv[k] = 0;
        if (mbusy[k] > 0) begin
          mbusy[k]--;
          if (mbusy[k] == 0) begin
            mvv[k] = 1; mval[k] = mpend[k]; mn[k] = 0;
          end
        end else if (v) begin
          if (mbrk[k]) mbrk[k] = 0;
          else if (mext[k]) begin
            if (b == 8'hF0) begin mext[k] = 0; mbrk[k] = 1; end
            else if (b != 8'hE0) begin
              mext[k] = 0;
              if (b == 8'h5A) start_conv(k, md);
            end
          end
          else if (b == 8'hF0) mbrk[k] = 1;
          else if (b == 8'hE0) mext[k] = 1;
          else if (d >= 0) begin
            if (mn[k] < md) begin mdig[k][mn[k]] = d; mn[k]++; end
          end
          else if (b == 8'h66) begin if (mn[k] > 0) mn[k]--; end
          else if (b == 8'h76) mn[k] = 0;
          else if (b == 8'h5A) start_conv(k, md);
        end
      end
    end
  endfunction

  function automatic logic [63:0] mbcd(int k);
    logic [63:0] s = 0;
    for (int i = 0; i < mn[k]; i++) s = (s << 4) | 64'(mdig[k][i]);
    return s;
  endfunction

  task automatic check_model();
    chk("m3_busy", busy3, mbusy[0] > 0);
    chk("m3_vv",   vv3,   mvv[0]);
    chk("m3_val",  val3,  mval[0]);
    chk("m3_led",  led3,  mval[0] & 8'hFF);
    chk("m3_bcd",  bcd3,  mbcd(0));
    chk("m3_cnt",  cnt3,  mn[0]);
    chk("m3_full", full3, mn[0] == 3);
    chk("m6_busy", busy6, mbusy[1] > 0);
    chk("m6_vv",   vv6,   mvv[1]);
    chk("m6_val",  val6,  mval[1]);
    chk("m6_led",  led6,  mval[1] & 8'hFF);
    chk("m6_bcd",  bcd6,  mbcd(1));
    chk("m6_cnt",  cnt6,  mn[1]);
    chk("m6_full", full6, mn[1] == 6);
  endtask

  task automatic cyc(bit r, bit v, logic [7:0] b);
    @(negedge clk);
    reset = r; code = b; code_valid = v;
    @(posedge clk);
    model_edge(r, v, b);
    #1;
    check_model();
  endtask

  task automatic send(logic [7:0] b); cyc(0, 1, b); endtask
  task automatic idle(int n); for (int i = 0; i < n; i++) cyc(0, 0, 8'h00); endtask

  task automatic chk_zero(string nm);
    chk({nm, "_busy"}, busy3, 0); chk({nm, "_vv"}, vv3, 0);
    chk({nm, "_val"}, val3, 0);   chk({nm, "_bcd"}, bcd3, 0);
    chk({nm, "_cnt"}, cnt3, 0);   chk({nm, "_led"}, led3, 0);
    chk({nm, "_val6"}, val6, 0);  chk({nm, "_busy6"}, busy6, 0);
  endtask

  typedef struct {
    bit          v;
    logic [7:0]  b;
    logic [11:0] bcd;
    int          cnt;
    bit          busy;
    bit          vv;
    int          val;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1, 8'h16, 12'h001, 1, 0, 0, 0};
    tbl[1]  = '{1, 8'hF0, 12'h001, 1, 0, 0, 0};
    tbl[2]  = '{1, 8'h16, 12'h001, 1, 0, 0, 0};
    tbl[3]  = '{1, 8'h1E, 12'h012, 2, 0, 0, 0};
    tbl[4]  = '{1, 8'hF0, 12'h012, 2, 0, 0, 0};
    tbl[5]  = '{1, 8'h1E, 12'h012, 2, 0, 0, 0};
    tbl[6]  = '{1, 8'h26, 12'h123, 3, 0, 0, 0};
    tbl[7]  = '{1, 8'hF0, 12'h123, 3, 0, 0, 0};
    tbl[8]  = '{1, 8'h26, 12'h123, 3, 0, 0, 0};
    tbl[9]  = '{1, 8'h5A, 12'h123, 3, 1, 0, 0};
    tbl[10] = '{0, 8'h00, 12'h123, 3, 1, 0, 0};
    tbl[11] = '{0, 8'h00, 12'h123, 3, 1, 0, 0};
    tbl[12] = '{0, 8'h00, 12'h000, 0, 0, 1, 123};
    tbl[13] = '{0, 8'h00, 12'h000, 0, 0, 0, 123};

    cyc(1, 0, 8'h00);
    cyc(1, 0, 8'h00);
    chk_zero("reset");

    for (int i = 0; i < 14; i++) begin
      cyc(0, tbl[i].v, tbl[i].b);
      chk($sformatf("tbl%0d_bcd", i),  bcd3,  tbl[i].bcd);
      chk($sformatf("tbl%0d_cnt", i),  cnt3,  tbl[i].cnt);
      chk($sformatf("tbl%0d_busy", i), busy3, tbl[i].busy);
      chk($sformatf("tbl%0d_vv", i),   vv3,   tbl[i].vv);
      chk($sformatf("tbl%0d_val", i),  val3,  tbl[i].val);
    end
    chk("led_123", led3, 8'h7B);

    // keypad digits and extended Enter
    send(8'h69); send(8'h70); send(8'hE0); send(8'h5A);
    idle(2);
    chk("kp_vv_early", vv3, 0);
    idle(1);
    chk("kp_vv", vv3, 1);
    chk("kp_val", val3, 10);
    send(8'hE0); send(8'hF0); send(8'h5A);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("ext_break_vv", vv3, 0);
    end
    chk("ext_break_val", val3, 10);

    // overflow, backspace
    send(8'h46); send(8'h46); send(8'h46); send(8'h16);
    chk("ovf_full", full3, 1);
    chk("ovf_bcd", bcd3, 12'h999);
    send(8'h66);
    chk("bs_bcd", bcd3, 12'h099);
    chk("bs_cnt", cnt3, 2);
    send(8'h45);
    chk("bs_bcd2", bcd3, 12'h990);
    send(8'h5A); idle(3);
    chk("ovf_vv", vv3, 1);
    chk("ovf_val", val3, 990);
    idle(4);

    // escape then empty Enter
    send(8'h25); send(8'h76);
    chk("esc_bcd", bcd3, 0);
    chk("esc_cnt", cnt3, 0);
    send(8'h5A);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("empty_vv", vv3, 0);
    end
    chk("empty_val", val3, 990);

    // bytes strobed while busy are dropped
    send(8'h3D); send(8'h5A);
    send(8'h16); send(8'hF0);
    idle(1);
    chk("drop_vv", vv3, 1);
    chk("drop_val", val3, 7);
    chk("drop_cnt", cnt3, 0);
    send(8'h16);
    chk("drop_make", bcd3, 12'h001);
    idle(4);
    send(8'h76);

    // reset on the second busy cycle
    send(8'h16); send(8'h1E); send(8'h5A);
    idle(1);
    chk("mid_busy", busy3, 1);
    cyc(1, 0, 8'h00);
    chk_zero("midrst");
    for (int i = 0; i < 7; i++) begin
      idle(1);
      chk("midrst_vv", vv3, 0);
    end
    send(8'h26); send(8'h5A); idle(3);
    chk("post_rst_val", val3, 3);
    idle(4);

    // six-digit instance
    cyc(1, 0, 8'h00);
    send(8'h46); send(8'hF0); send(8'h46); send(8'h7D);
    send(8'h46); send(8'h46); send(8'h46); send(8'h46);
    chk("six_bcd", bcd6, 24'h999999);
    chk("six_full", full6, 1);
    send(8'h5A);
    idle(5);
    chk("six_vv_early", vv6, 0);
    idle(1);
    chk("six_vv", vv6, 1);
    chk("six_val", val6, 999999);
    chk("six_led", led6, 8'h3F);
    idle(2);

    // six-digit reset mid conversion
    send(8'h16); send(8'h36); send(8'h5A); idle(1);
    cyc(1, 0, 8'h00);
    chk_zero("midrst6");
    idle(8);

    // random byte stream
    for (int it = 0; it < 3000; it++) begin
      int sel = $urandom_range(0, 19);
      logic [7:0] b;
      bit v = ($urandom_range(0, 3) != 0);
      if (sel < 9)
        b = ($urandom_range(0, 1) != 0) ? kmain[$urandom_range(0, 9)][7:0]
                                        : kpad[$urandom_range(0, 9)][7:0];
      else if (sel < 11) b = 8'hF0;
      else if (sel < 13) b = 8'hE0;
      else if (sel < 15) b = 8'h5A;
      else if (sel < 16) b = 8'h66;
      else if (sel < 17) b = 8'h76;
      else b = 8'($urandom_range(0, 255));
      cyc(($urandom_range(0, 299) == 0), v, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
